uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL provide parameter DBIT, default 8, number of data bits per frame.
REQ-002 SHALL provide parameter SB_TICK, default 16, number of s_tick pulses in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 SHALL provide port clk  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port tx_start  input  1  request to send din; sampled only in IDLE.
REQ-006 SHALL provide port s_tick  input  1  one-clk-wide enable pulse at 16x baud rate, from the baud generator.
REQ-007 SHALL provide port din  input  DBIT  byte to transmit.
REQ-008 SHALL provide port tx_done_tick  output  1  one-clk pulse at frame completion.
REQ-009 SHALL provide port tx_busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL provide port tx  output  1  serial line, idle high, driven from a register (glitch-free).

Function
REQ-011 SHALL implement states IDLE, START, DATA, PARITY (only with UART_TX_PARITY_EN), STOP.
REQ-012 SHALL, in IDLE with tx_start=1 at a clk edge: latch din into shift register, clear tick counter, enter START, drive tx=0 from the next cycle.
REQ-013 SHALL ignore tx_start while not in IDLE; din changes after acceptance do not affect the frame.
REQ-014 SHALL advance the 4-bit tick counter only on clk edges where s_tick=1; clk cycles without s_tick hold all state.
REQ-015 SHALL hold START for 16 s_ticks; on the 16th, enter DATA with tx = shift register bit 0.
REQ-016 SHALL send data LSB first, each bit held 16 s_ticks, shifting right and incrementing a bit counter (width clog2(DBIT)) on each 16th tick.
REQ-017 SHALL, after bit DBIT-1 completes, enter PARITY if enabled, otherwise STOP with tx=1.
REQ-018 SHALL hold STOP (tx=1) for SB_TICK s_ticks; on the last, assert tx_done_tick for exactly that clk cycle and return to IDLE.
REQ-019 SHALL allow back-to-back frames: tx_start=1 in the first IDLE cycle after tx_done_tick starts the next START with no extra idle bit.
REQ-020 SHALL use a tick counter wide enough for SB_TICK-1; counter wraps to 0 at each bit boundary.
REQ-021 SHALL keep tx_done_tick low in every cycle other than REQ-018.

Reset
REQ-022 SHALL, on reset=1 asynchronously, force state=IDLE, tick counter=0, bit counter=0, shift register=0, tx=1, tx_busy=0, tx_done_tick=0.
REQ-023 SHALL, on reset mid-frame, abort the frame immediately with tx=1 and no tx_done_tick.
REQ-024 SHALL accept tx_start on the first rising edge after reset deasserts.

Configuration
REQ-025 SHALL support macro UART_TX_PARITY_EN.
REQ-026 SHALL, with UART_TX_PARITY_EN defined, insert PARITY between DATA and STOP: tx = XOR of the latched DBIT data bits (even parity), held 16 s_ticks.
REQ-027 SHALL, without UART_TX_PARITY_EN, contain no PARITY state or parity logic; frame = start + DBIT data + stop.

Verification
REQ-028 SHALL check: reset high 100 ns, then low, no tx_start -> tx=1, tx_busy=0, tx_done_tick=0 throughout.
REQ-029 SHALL check: s_tick every clk, din=8'hA5, tx_start one cycle -> tx = 0,1,0,1,0,0,1,0,1,1, each held 16 clk; tx_done_tick one pulse 160 clk after START entry.
REQ-030 SHALL check: s_tick every 4th clk, din=8'h3C -> each bit held 64 clk; correct bit order; done pulse at end of stop.
REQ-031 SHALL check: tx_start pulsed and din changed to 8'hFF mid-frame of 8'h00 -> frame still 8'h00; no second frame started.
REQ-032 SHALL check: reset asserted during DATA bit 3 -> tx=1 and state IDLE within the same cycle; no tx_done_tick; next 8'h55 frame correct.
REQ-033 SHALL check with UART_TX_PARITY_EN: din=8'h07 -> parity bit 1; din=8'h03 -> parity bit 0; frame 176 clk at s_tick every clk.

Source files
------------

// File: rtl/uart_tx_if.sv
// uart_tx_if: request/data/status bundle between a transmit client and uart_tx.
// The master side drives the request, baud tick and data. The slave side is the transmitter.
interface uart_tx_if #(
    parameter int DBIT = 8
);
    logic            tx_start;
    logic            s_tick;
    logic [DBIT-1:0] din;
    logic            tx_done_tick;
    logic            tx_busy;
    logic            tx;

    modport master (
        output tx_start,
        output s_tick,
        output din,
        input  tx_done_tick,
        input  tx_busy,
        input  tx
    );

    modport slave (
        input  tx_start,
        input  s_tick,
        input  din,
        output tx_done_tick,
        output tx_busy,
        output tx
    );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: UART serializer timed by a 16x-baud s_tick enable.
// A frame is one start bit, then DBIT data bits sent LSB first, then a stop bit of SB_TICK ticks.
// Optional macro UART_TX_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
//
// state  | meaning
// IDLE   | line high, waiting for tx_start
// START  | start bit (tx=0), 16 ticks
// DATA   | data bits LSB first, 16 ticks each
// PARITY | even parity of latched byte, 16 ticks (UART_TX_PARITY_EN only)
// STOP   | stop bit (tx=1), SB_TICK ticks, done pulse on last tick
module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic     clk,
    input  logic     reset,
    uart_tx_if.slave bus
);
    localparam int TW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int BW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(15);
    localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DBIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [DBIT-1:0] shift_q, shift_d;
    logic            tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic            parity_q, parity_d;
`endif

    // State and datapath registers; reset drops the line high and abandons any frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next state: the registered line value for the next cycle is computed here, so tx is glitch-free.
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (bus.tx_start) begin
                    state_d  = START;
                    tick_d   = '0;
                    shift_d  = bus.din;
                    tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^bus.din;
`endif
                end
            end
            START: begin
                if (bus.s_tick) begin
                    if (tick_q == TICK_LAST) begin
                        state_d = DATA;
                        tick_d  = '0;
                        bit_d   = '0;
                        tx_d    = shift_q[0];
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            DATA: begin
                if (bus.s_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        shift_d = shift_q >> 1;
                        if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_d = PARITY;
                            tx_d    = parity_q;
`else
                            state_d = STOP;
                            tx_d    = 1'b1;
`endif
                        end else begin
                            bit_d = bit_q + BW'(1);
                            tx_d  = shift_d[0];
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bus.s_tick) begin
                    if (tick_q == TICK_LAST) begin
                        state_d = STOP;
                        tick_d  = '0;
                        tx_d    = 1'b1;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
`endif
            STOP: begin
                tx_d = 1'b1;
                if (bus.s_tick) begin
                    if (tick_q == STOP_LAST) begin
                        state_d = IDLE;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Outputs: the done pulse covers the cycle whose closing edge ends the stop bit, so a new request can follow directly.
    always_comb begin
        bus.tx           = tx_q;
        bus.tx_busy      = (state_q != IDLE);
        bus.tx_done_tick = (state_q == STOP) && bus.s_tick && (tick_q == STOP_LAST);
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx.
// Inputs change on the falling edge. Outputs are sampled 1 ns later, well before the next rising edge.
module tb_uart_tx;
    localparam int DBIT    = 8;
    localparam int SB_TICK = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    uart_tx_if #(.DBIT(DBIT)) bus ();

    uart_tx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected line level for frame bit position idx: start, data LSB first, optional parity, stop.
    function automatic logic frame_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= DBIT) return d[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == DBIT + 1) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic test_reset();
        bus.tx_start = 1'b0;
        bus.s_tick   = 1'b0;
        bus.din      = '0;
        reset        = 1'b1;
        #50;
        n_checks++;
        if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: tx=%b busy=%b done=%b expected 1 0 0", bus.tx, bus.tx_busy, bus.tx_done_tick);
        end
        repeat (10) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            bus.s_tick = 1'b1;
            #1;
            n_checks++;
            if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done_tick !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle: k=%0d tx=%b busy=%b done=%b expected 1 0 0", k, bus.tx, bus.tx_busy, bus.tx_done_tick);
            end
        end
    endtask

    task automatic test_frame_a5();
        logic [7:0] d = 8'hA5;
        int len = FRAME_BITS * 16;
        bus.din      = d;
        bus.tx_start = 1'b1;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            bus.tx_start = 1'b0;
            bus.s_tick   = 1'b1;
            #1;
            n_checks++;
            if (bus.tx !== frame_bit(d, k / 16)) begin
                n_fail++;
                $display("FAIL a5_tx: k=%0d tx=%b expected %b", k, bus.tx, frame_bit(d, k / 16));
            end
            n_checks++;
            if (bus.tx_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL a5_busy: k=%0d busy=%b expected 1", k, bus.tx_busy);
            end
            n_checks++;
            if (bus.tx_done_tick !== logic'(k == len - 1)) begin
                n_fail++;
                $display("FAIL a5_done: k=%0d done=%b expected %b", k, bus.tx_done_tick, k == len - 1);
            end
        end
        @(negedge clk);
        bus.s_tick = 1'b0;
        #1;
        n_checks++;
        if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL a5_end: tx=%b busy=%b done=%b expected 1 0 0", bus.tx, bus.tx_busy, bus.tx_done_tick);
        end
    endtask

    task automatic test_slow_tick();
        logic [7:0] d = 8'h3C;
        int p = 4;
        int len = FRAME_BITS * 16 * p;
        bus.din      = d;
        bus.tx_start = 1'b1;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            bus.tx_start = 1'b0;
            bus.s_tick   = ((k + 1) % p == 0);
            #1;
            n_checks++;
            if (bus.tx !== frame_bit(d, k / (16 * p))) begin
                n_fail++;
                $display("FAIL slow_tx: k=%0d tx=%b expected %b", k, bus.tx, frame_bit(d, k / (16 * p)));
            end
            n_checks++;
            if (bus.tx_done_tick !== logic'(k == len - 1)) begin
                n_fail++;
                $display("FAIL slow_done: k=%0d done=%b expected %b", k, bus.tx_done_tick, k == len - 1);
            end
        end
        @(negedge clk);
        bus.s_tick = 1'b0;
        #1;
        n_checks++;
        if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL slow_end: tx=%b busy=%b expected 1 0", bus.tx, bus.tx_busy);
        end
    endtask

    task automatic test_ignore_midframe();
        logic [7:0] d = 8'h00;
        int len = FRAME_BITS * 16;
        bus.din      = d;
        bus.tx_start = 1'b1;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            bus.tx_start = (k == 40);
            if (k == 40) bus.din = 8'hFF;
            bus.s_tick = 1'b1;
            #1;
            n_checks++;
            if (bus.tx !== frame_bit(d, k / 16)) begin
                n_fail++;
                $display("FAIL ignore_tx: k=%0d tx=%b expected %b", k, bus.tx, frame_bit(d, k / 16));
            end
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            bus.tx_start = 1'b0;
            #1;
            n_checks++;
            if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done_tick !== 1'b0) begin
                n_fail++;
                $display("FAIL ignore_no_second: k=%0d tx=%b busy=%b done=%b expected 1 0 0", k, bus.tx, bus.tx_busy, bus.tx_done_tick);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d = 8'hC3;
        logic [7:0] d2 = 8'h55;
        int len = FRAME_BITS * 16;
        bus.din      = d;
        bus.tx_start = 1'b1;
        for (int k = 0; k <= 70; k++) begin
            @(negedge clk);
            bus.tx_start = 1'b0;
            bus.s_tick   = 1'b1;
            #1;
            n_checks++;
            if (bus.tx !== frame_bit(d, k / 16)) begin
                n_fail++;
                $display("FAIL rst_pre_tx: k=%0d tx=%b expected %b", k, bus.tx, frame_bit(d, k / 16));
            end
        end
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_abort: tx=%b busy=%b done=%b expected 1 0 0", bus.tx, bus.tx_busy, bus.tx_done_tick);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (bus.tx !== 1'b1 || bus.tx_done_tick !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_held: k=%0d tx=%b done=%b expected 1 0", k, bus.tx, bus.tx_done_tick);
            end
        end
        @(negedge clk);
        reset        = 1'b0;
        bus.din      = d2;
        bus.tx_start = 1'b1;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            bus.tx_start = 1'b0;
            bus.s_tick   = 1'b1;
            #1;
            n_checks++;
            if (bus.tx !== frame_bit(d2, k / 16)) begin
                n_fail++;
                $display("FAIL rst_next_tx: k=%0d tx=%b expected %b", k, bus.tx, frame_bit(d2, k / 16));
            end
            n_checks++;
            if (bus.tx_done_tick !== logic'(k == len - 1)) begin
                n_fail++;
                $display("FAIL rst_next_done: k=%0d done=%b expected %b", k, bus.tx_done_tick, k == len - 1);
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        int len = FRAME_BITS * 16;
        for (int f = 0; f < 2; f++) begin
            d = (f == 0) ? 8'h81 : 8'h7E;
            bus.din      = d;
            bus.tx_start = 1'b1;
            for (int k = 0; k < len; k++) begin
                @(negedge clk);
                bus.tx_start = 1'b0;
                bus.s_tick   = 1'b1;
                #1;
                n_checks++;
                if (bus.tx !== frame_bit(d, k / 16) || bus.tx_busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_tx: f=%0d k=%0d tx=%b busy=%b expected %b 1", f, k, bus.tx, bus.tx_busy, frame_bit(d, k / 16));
                end
                n_checks++;
                if (bus.tx_done_tick !== logic'(k == len - 1)) begin
                    n_fail++;
                    $display("FAIL b2b_done: f=%0d k=%0d done=%b expected %b", f, k, bus.tx_done_tick, k == len - 1);
                end
            end
            @(negedge clk);
            #1;
            n_checks++;
            if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_gap: f=%0d tx=%b busy=%b expected 1 0", f, bus.tx, bus.tx_busy);
            end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] d;
        logic       exp_par;
        int len = 176;
        for (int f = 0; f < 2; f++) begin
            d       = (f == 0) ? 8'h07 : 8'h03;
            exp_par = (f == 0) ? 1'b1 : 1'b0;
            bus.din      = d;
            bus.tx_start = 1'b1;
            for (int k = 0; k < len; k++) begin
                @(negedge clk);
                bus.tx_start = 1'b0;
                bus.s_tick   = 1'b1;
                #1;
                if (k / 16 == 9) begin
                    n_checks++;
                    if (bus.tx !== exp_par) begin
                        n_fail++;
                        $display("FAIL parity_bit: f=%0d k=%0d tx=%b expected %b", f, k, bus.tx, exp_par);
                    end
                end
                n_checks++;
                if (bus.tx_done_tick !== logic'(k == len - 1)) begin
                    n_fail++;
                    $display("FAIL parity_done: f=%0d k=%0d done=%b expected %b", f, k, bus.tx_done_tick, k == len - 1);
                end
            end
            @(negedge clk);
            #1;
            n_checks++;
            if (bus.tx_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL parity_len: f=%0d busy=%b expected 0", f, bus.tx_busy);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frame_a5();
        test_slow_tick();
        test_ignore_midframe();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
